// File: rtl/cix32_hazard_ctrl_pkg.sv
// cix32_hazard_ctrl_pkg: shared types, widths and the stall-vector helper for the hazard unit.
package cix32_hazard_ctrl_pkg;

    localparam int HZ_REG_ADDR_W = 4;
    localparam int HZ_MC_LAT_W   = 6;
    localparam int HZ_PERF_W     = 32;

    typedef enum logic {HZ_IDLE, HZ_MC_WAIT} hz_state_t;

    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic stall_execute;
        logic stall_memory;
        logic flush;
    } hz_ctrl_t;

    // Stalls are expressed as a depth from fetch so the upstream-monotonic property holds by construction.
    function automatic hz_ctrl_t hz_ctrl(input logic [2:0] depth, input logic flush);
        hz_ctrl_t c;
        c.stall_fetch   = depth >= 3'd1;
        c.stall_decode  = depth >= 3'd2;
        c.stall_execute = depth >= 3'd3;
        c.stall_memory  = depth >= 3'd4;
        c.flush         = flush;
        return c;
    endfunction

endpackage

// File: rtl/cix32_hazard_ctrl_if.sv
// cix32_hazard_ctrl_if: pipeline-side request and stall/flush/perf bundle of the hazard unit.
interface cix32_hazard_ctrl_if #(
    parameter int REG_ADDR_W = cix32_hazard_ctrl_pkg::HZ_REG_ADDR_W,
    parameter int MC_LAT_W   = cix32_hazard_ctrl_pkg::HZ_MC_LAT_W,
    parameter int PERF_W     = cix32_hazard_ctrl_pkg::HZ_PERF_W
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  ex_mc_start;
    logic [MC_LAT_W-1:0]   ex_mc_lat;
    logic                  ex_redirect;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  stall_fetch;
    logic                  stall_decode;
    logic                  stall_execute;
    logic                  stall_memory;
    logic                  flush_pipeline;
    logic                  hz_busy;
    logic [PERF_W-1:0]     perf_stall_cycles;
    logic [PERF_W-1:0]     perf_flushes;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_rd, ex_is_load, ex_mc_start, ex_mc_lat, ex_redirect,
        output mem_req, mem_ready,
        input  stall_fetch, stall_decode, stall_execute, stall_memory, flush_pipeline,
        input  hz_busy, perf_stall_cycles, perf_flushes
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_rd, ex_is_load, ex_mc_start, ex_mc_lat, ex_redirect,
        input  mem_req, mem_ready,
        output stall_fetch, stall_decode, stall_execute, stall_memory, flush_pipeline,
        output hz_busy, perf_stall_cycles, perf_flushes
    );
endinterface

// File: rtl/cix32_hazard_ctrl_perf.sv
// cix32_hazard_perf: free-running wrap-around stall-cycle and flush-event counters.
module cix32_hazard_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_en,
    input  logic              flush_en,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flushes
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flushes      <= '0;
        end else begin
            stall_cycles <= stall_cycles + PERF_W'(stall_en);
            flushes      <= flushes + PERF_W'(flush_en);
        end
    end
endmodule

// File: rtl/cix32_hazard_ctrl.sv
// cix32_hazard_ctrl: load-use, multi-cycle, memory-wait and redirect stall/flush control for the 5-stage core.
module cix32_hazard_ctrl
    import cix32_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int MC_LAT_W   = HZ_MC_LAT_W,
    parameter int PERF_W     = HZ_PERF_W
) (
    input logic                clk,
    input logic                rst_n,
    cix32_hazard_ctrl_if.slave hz
);
    hz_state_t             state, state_n;
    logic [MC_LAT_W-1:0]   cnt, cnt_n;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  mem_stall, redirect, mc_start, mc_stall, lu_hz;
    hz_ctrl_t              ctrl;

    assign rs1       = hz.id_rs1;
    assign rs2       = hz.id_rs2;
    assign rd        = hz.ex_rd;
    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign redirect  = hz.ex_redirect & hz.ex_valid;
    assign mc_start  = hz.ex_valid & hz.ex_mc_start & (hz.ex_mc_lat != '0) & (state == HZ_IDLE);
    assign mc_stall  = (state == HZ_MC_WAIT) | mc_start;
    assign lu_hz     = hz.id_valid & hz.ex_valid & hz.ex_is_load &
                       ((hz.id_rs1_used & (rs1 == rd)) | (hz.id_rs2_used & (rs2 == rd)));

    always_comb begin
        ctrl = !rst_n    ? hz_ctrl(3'd0, 1'b0) :
               mem_stall ? hz_ctrl(3'd4, 1'b0) :
               redirect  ? hz_ctrl(3'd0, 1'b1) :
               mc_stall  ? hz_ctrl(3'd3, 1'b0) :
               lu_hz     ? hz_ctrl(3'd2, 1'b0) :
                           hz_ctrl(3'd0, 1'b0);
    end

    // The start cycle in IDLE already counts as one stall cycle, so MC_WAIT covers the remaining lat-1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!mem_stall) begin
            if (redirect) begin
                state_n = HZ_IDLE;
                cnt_n   = '0;
            end else if (state == HZ_MC_WAIT) begin
                cnt_n   = cnt - 1'b1;
                state_n = (cnt == MC_LAT_W'(1)) ? HZ_IDLE : HZ_MC_WAIT;
            end else if (mc_start) begin
                cnt_n   = hz.ex_mc_lat - 1'b1;
                state_n = (hz.ex_mc_lat == MC_LAT_W'(1)) ? HZ_IDLE : HZ_MC_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign hz.stall_fetch    = ctrl.stall_fetch;
    assign hz.stall_decode   = ctrl.stall_decode;
    assign hz.stall_execute  = ctrl.stall_execute;
    assign hz.stall_memory   = ctrl.stall_memory;
    assign hz.flush_pipeline = ctrl.flush;
    assign hz.hz_busy        = state != HZ_IDLE;

    cix32_hazard_perf #(.PERF_W(PERF_W)) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_en     (ctrl.stall_fetch),
        .flush_en     (ctrl.flush),
        .stall_cycles (hz.perf_stall_cycles),
        .flushes      (hz.perf_flushes)
    );
endmodule

// File: tb/tb_cix32_hazard_ctrl.sv
// tb_cix32_hazard_ctrl: directed and random stimulus against a cycle-count reference model with a queue scoreboard.
module tb_cix32_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cix32_hazard_ctrl_if #(.REG_ADDR_W(4), .MC_LAT_W(6), .PERF_W(32)) hz ();

    cix32_hazard_ctrl #(.REG_ADDR_W(4), .MC_LAT_W(6), .PERF_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct packed {
        logic       rst_n;
        logic       id_valid;
        logic [3:0] id_rs1;
        logic [3:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic       ex_valid;
        logic [3:0] ex_rd;
        logic       ex_is_load;
        logic       ex_mc_start;
        logic [5:0] ex_mc_lat;
        logic       ex_redirect;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    typedef struct packed {
        logic [3:0]  stall;
        logic        flush;
        logic        busy;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          compared = 0;
    int          mismatched = 0;
    int          rem = 0;
    logic [31:0] m_ps = '0;
    logic [31:0] m_pf = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("stalls", {28'h0, hz.stall_fetch, hz.stall_decode, hz.stall_execute, hz.stall_memory}, {28'h0, mon_e.stall});
            check("flush", {31'h0, hz.flush_pipeline}, {31'h0, mon_e.flush});
            check("busy", {31'h0, hz.hz_busy}, {31'h0, mon_e.busy});
            check("perf_stall_cycles", hz.perf_stall_cycles, mon_e.ps);
            check("perf_flushes", hz.perf_flushes, mon_e.pf);
        end
    end

    // Model: rem counts stall cycles still owed to a multi-cycle op beyond its start cycle.
    task automatic apply(input stim_t s);
        int   lvl;
        logic mem, redir, start, lu, fl;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = s.rst_n;
        hz.id_valid    = s.id_valid;
        hz.id_rs1      = s.id_rs1;
        hz.id_rs2      = s.id_rs2;
        hz.id_rs1_used = s.id_rs1_used;
        hz.id_rs2_used = s.id_rs2_used;
        hz.ex_valid    = s.ex_valid;
        hz.ex_rd       = s.ex_rd;
        hz.ex_is_load  = s.ex_is_load;
        hz.ex_mc_start = s.ex_mc_start;
        hz.ex_mc_lat   = s.ex_mc_lat;
        hz.ex_redirect = s.ex_redirect;
        hz.mem_req     = s.mem_req;
        hz.mem_ready   = s.mem_ready;
        e = '0;
        if (!s.rst_n) begin
            rem  = 0;
            m_ps = '0;
            m_pf = '0;
            sb.push_back(e);
            return;
        end
        mem   = s.mem_req && !s.mem_ready;
        redir = s.ex_redirect && s.ex_valid;
        start = s.ex_valid && s.ex_mc_start && s.ex_mc_lat != 0 && rem == 0;
        lu    = s.id_valid && s.ex_valid && s.ex_is_load &&
                ((s.id_rs1_used && s.id_rs1 == s.ex_rd) || (s.id_rs2_used && s.id_rs2 == s.ex_rd));
        lvl   = mem ? 4 : redir ? 0 : (rem > 0 || start) ? 3 : lu ? 2 : 0;
        fl    = !mem && redir;
        for (int i = 0; i < 4; i++) e.stall[3-i] = i < lvl;
        e.flush = fl;
        e.busy  = rem > 0;
        e.ps    = m_ps;
        e.pf    = m_pf;
        sb.push_back(e);
        m_ps = m_ps + 32'(lvl > 0);
        m_pf = m_pf + 32'(fl);
        if (!mem) begin
            if (redir) rem = 0;
            else if (rem > 0) rem--;
            else if (start) rem = int'(s.ex_mc_lat) - 1;
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.mem_ready = 1'b1;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = nop();
        s.rst_n = 1'b0;
        apply(s);
        apply(s);
        s = nop();
        s.ex_valid = 1; s.ex_is_load = 1; s.ex_rd = 5;
        s.id_valid = 1; s.id_rs1 = 5; s.id_rs1_used = 1;
        apply(s);
        apply(nop());
        s = nop();
        s.ex_valid = 1; s.ex_is_load = 1; s.ex_rd = 5;
        s.id_valid = 1; s.id_rs1 = 2; s.id_rs1_used = 1; s.id_rs2 = 5; s.id_rs2_used = 0;
        apply(s);
        s = nop();
        s.ex_valid = 1; s.ex_mc_start = 1; s.ex_mc_lat = 3;
        apply(s);
        s.ex_mc_start = 0;
        repeat (3) apply(s);
        s.ex_mc_start = 1; s.ex_mc_lat = 6;
        apply(s);
        s.ex_mc_start = 0;
        repeat (2) apply(s);
        s.mem_req = 1; s.mem_ready = 0;
        repeat (4) apply(s);
        s.mem_req = 0; s.mem_ready = 1;
        repeat (5) apply(s);
        s = nop();
        s.ex_valid = 1; s.ex_is_load = 1; s.ex_rd = 5;
        s.id_valid = 1; s.id_rs1 = 5; s.id_rs1_used = 1;
        s.ex_mc_start = 1; s.ex_mc_lat = 4; s.ex_redirect = 1;
        apply(s);
        apply(nop());
        s = nop();
        s.ex_valid = 1; s.ex_mc_start = 1; s.ex_mc_lat = 20;
        apply(s);
        s.ex_mc_start = 0;
        repeat (9) apply(s);
        s.rst_n = 0;
        apply(s);
        repeat (2) apply(nop());
        repeat (3000) begin
            s.rst_n       = $urandom_range(0, 499) != 0;
            s.id_valid    = $urandom_range(0, 3) != 0;
            s.id_rs1      = 4'($urandom_range(0, 3));
            s.id_rs2      = 4'($urandom_range(0, 3));
            s.id_rs1_used = 1'($urandom);
            s.id_rs2_used = 1'($urandom);
            s.ex_valid    = $urandom_range(0, 4) != 0;
            s.ex_rd       = 4'($urandom_range(0, 3));
            s.ex_is_load  = $urandom_range(0, 9) < 3;
            s.ex_mc_start = $urandom_range(0, 9) == 0;
            s.ex_mc_lat   = $urandom_range(0, 1) != 0 ? 6'($urandom_range(0, 4)) : 6'($urandom_range(0, 63));
            s.ex_redirect = $urandom_range(0, 19) == 0;
            s.mem_req     = $urandom_range(0, 9) < 3;
            s.mem_ready   = $urandom_range(0, 9) < 6;
            apply(s);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
